// File: rtl/sint_running_min_pkg.sv
// rtl/sint_running_min_pkg.sv - shared types and constants for the signed running-minimum stage
package sint_running_min_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 7;
    localparam int DEF_CNT_W = 8;

    // Largest value the sample counter can hold before it saturates.
    function automatic int unsigned sat_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/sint_running_min_if.sv
// rtl/sint_running_min_if.sv - sample input stream and result output stream
interface sint_running_min_if
    import sint_running_min_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic signed [WIDTH-1:0] I;
    logic                    I_valid;
    logic                    I_last;
    logic                    I_ready;
    logic signed [WIDTH-1:0] O_min;
    logic [CNT_W-1:0]        O_idx;
    logic                    O_ovf;
    logic                    O_valid;
    logic                    O_ready;

    modport master (
        output I, I_valid, I_last, O_ready,
        input  I_ready, O_min, O_idx, O_ovf, O_valid
    );

    modport slave (
        input  I, I_valid, I_last, O_ready,
        output I_ready, O_min, O_idx, O_ovf, O_valid
    );
endinterface

// File: rtl/sint_running_min_slt.sv
// rtl/sint_running_min_slt.sv - signed less-than primitive
module coreir_slt #(
    parameter int width = 16
) (
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    output logic             out
);
    // Pure comparison: no subtraction, so the extremes cannot overflow.
    assign out = $signed(in0) < $signed(in1);
endmodule

// File: rtl/sint_running_min.sv
// rtl/sint_running_min.sv - per-frame signed minimum, first index and length overflow
module sint_running_min
    import sint_running_min_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic               CLK,
    input logic               ASYNCRESETN,
    sint_running_min_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    state_t                  state;
    state_t                  state_nx;
    logic signed [WIDTH-1:0] min_r;
    logic [CNT_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    sat_r;
    logic                    ovf_r;
    logic                    lt;
    logic                    accept;

    coreir_slt #(.width(WIDTH)) u_slt (
        .in0 (bus.I),
        .in1 (min_r),
        .out (lt)
    );

    assign accept      = bus.I_valid && (state != HOLD);
    assign bus.I_ready = (state != HOLD);
    assign bus.O_valid = (state == HOLD);
    assign bus.O_min   = min_r;
    assign bus.O_idx   = idx_r;
    assign bus.O_ovf   = ovf_r;

    // State register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: frame start, frame end on the last beat, release on result handshake.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bus.I_last ? HOLD : ACCUM;
            ACCUM:   if (accept && bus.I_last) state_nx = HOLD;
            HOLD:    if (bus.O_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Running minimum, first index and saturating counter; sat_r marks that the
    // sample at index CNT_MAX was taken, so any further sample overflows the frame.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            min_r <= '0;
            idx_r <= '0;
            cnt_r <= '0;
            sat_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                min_r <= bus.I;
                idx_r <= '0;
                cnt_r <= CNT_W'(1);
                sat_r <= 1'b0;
                ovf_r <= 1'b0;
            end else begin
                if (lt) begin
                    min_r <= bus.I;
                    idx_r <= cnt_r;
                end
                if (cnt_r == CNT_MAX) begin
                    if (sat_r) ovf_r <= 1'b1;
                    sat_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sint_running_min.sv
// tb/tb_sint_running_min.sv - randomized and directed checks against a frame-level model
module tb_sint_running_min;
    import sint_running_min_pkg::*;

    localparam int W   = 7;
    localparam int CW  = 8;
    localparam int CWS = 2;

    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b0;
    always #5 CLK = ~CLK;

    sint_running_min_if #(.WIDTH(W), .CNT_W(CW))  bus ();
    sint_running_min_if #(.WIDTH(W), .CNT_W(CWS)) bus_s ();

    sint_running_min #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .bus         (bus.slave)
    );

    sint_running_min #(.WIDTH(W), .CNT_W(CWS)) dut_s (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .bus         (bus_s.slave)
    );

    assign bus_s.I       = bus.I;
    assign bus_s.I_valid = bus.I_valid;
    assign bus_s.I_last  = bus.I_last;
    assign bus_s.O_ready = bus.O_ready;

    int checks   = 0;
    int errors   = 0;
    int sent     = 0;
    int consumed = 0;
    int ready_mode = 1;
    bit gap_en   = 1'b0;

    logic signed [W-1:0] fr[$];
    logic signed [W-1:0] q[$];
    bit exp_hold = 1'b0;
    int exp_min, exp_idx, exp_idx_s, exp_ovf, exp_ovf_s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame result from first principles: minimum, first index capped at the
    // counter limit, overflow when the frame is longer than 2^cw samples.
    task automatic model_result(input int cw, output int mn, output int idx, output int ovf);
        int lim;
        int fi;
        lim = 1 << cw;
        mn  = int'(q[0]);
        fi  = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (int'(q[i]) < mn) begin
                mn = int'(q[i]);
                fi = i;
            end
        end
        idx = (fi > lim - 1) ? lim - 1 : fi;
        ovf = (q.size() > lim) ? 1 : 0;
    endtask

    // Compare process: checks both DUTs every cycle, then advances the model
    // by what the coming clock edge will transfer.
    always @(negedge CLK) begin
        int mn;
        if (!ASYNCRESETN) begin
            q.delete();
            exp_hold = 1'b0;
            chk("rst_o_valid", int'(bus.O_valid), 0);
            chk("rst_i_ready", int'(bus.I_ready), 1);
            chk("rst_o_min", int'(bus.O_min), 0);
            chk("rst_o_idx", int'(bus.O_idx), 0);
            chk("rst_o_ovf", int'(bus.O_ovf), 0);
            chk("rst_s_o_valid", int'(bus_s.O_valid), 0);
        end else begin
            chk("o_valid", int'(bus.O_valid), int'(exp_hold));
            chk("i_ready", int'(bus.I_ready), int'(!exp_hold));
            chk("s_o_valid", int'(bus_s.O_valid), int'(exp_hold));
            chk("s_i_ready", int'(bus_s.I_ready), int'(!exp_hold));
            if (exp_hold) begin
                chk("o_min", int'(bus.O_min), exp_min);
                chk("o_idx", int'(bus.O_idx), exp_idx);
                chk("o_ovf", int'(bus.O_ovf), exp_ovf);
                chk("s_o_min", int'(bus_s.O_min), exp_min);
                chk("s_o_idx", int'(bus_s.O_idx), exp_idx_s);
                chk("s_o_ovf", int'(bus_s.O_ovf), exp_ovf_s);
            end
            if (exp_hold && bus.O_ready) begin
                exp_hold = 1'b0;
                consumed++;
            end else if (!exp_hold && bus.I_valid) begin
                q.push_back(bus.I);
                if (bus.I_last) begin
                    model_result(CW, exp_min, exp_idx, exp_ovf);
                    model_result(CWS, mn, exp_idx_s, exp_ovf_s);
                    q.delete();
                    exp_hold = 1'b1;
                end
            end
        end
    end

    // Result-side back-pressure.
    initial begin
        bus.O_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       bus.O_ready = 1'b0;
                1:       bus.O_ready = 1'b1;
                default: bus.O_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Offer one sample until accepted; returns just after the accepting edge.
    task automatic put(input logic signed [W-1:0] v, input bit last);
        bit acc;
        int budget;
        if (gap_en) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.I_valid = 1'b0;
                @(posedge CLK);
                #1;
            end
        end
        bus.I       = v;
        bus.I_last  = last;
        bus.I_valid = 1'b1;
        budget = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge CLK);
            acc = bus.I_ready;
            @(posedge CLK);
            #1;
            budget++;
            if (!acc && budget > 1000) begin
                chk("put_timeout", 0, 1);
                acc = 1'b1;
            end
        end
        bus.I_valid = 1'b0;
        bus.I_last  = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fr.size(); i++) put(fr[i], i == fr.size() - 1);
        sent++;
    endtask

    task automatic add(input int v);
        fr.push_back(W'(v));
    endtask

    // Wait for a result with O_ready held high; capture both DUTs' outputs.
    task automatic wait_result(output int mn, output int idx, output int ovf,
                               output int idx_s, output int ovf_s, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        mn = 0; idx = 0; ovf = 0; idx_s = 0; ovf_s = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge CLK);
            lat++;
            if (bus.O_valid) begin
                mn    = int'(bus.O_min);
                idx   = int'(bus.O_idx);
                ovf   = int'(bus.O_ovf);
                idx_s = int'(bus_s.O_idx);
                ovf_s = int'(bus_s.O_ovf);
                got   = 1'b1;
            end
        end
        if (!got) chk("result_timeout", 0, 1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int mn, idx, ovf, idx_s, ovf_s, lat;
        bit gone;
        logic signed [W-1:0] v;
        int len;

        bus.I = '0;
        bus.I_valid = 1'b0;
        bus.I_last = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_o_valid", int'(bus.O_valid), 0);
        chk("reset_i_ready", int'(bus.I_ready), 1);
        chk("reset_o_min", int'(bus.O_min), 0);
        @(posedge CLK);
        #3;
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;

        // Mixed frame, minimum on the last beat.
        ready_mode = 1;
        fr.delete(); add(5); add(-3); add(12); add(-3); add(-64);
        send_frame();
        wait_result(mn, idx, ovf, idx_s, ovf_s, lat);
        chk("t1_min", mn, -64);
        chk("t1_idx", idx, 4);
        chk("t1_ovf", ovf, 0);
        chk("t1_latency", lat, 1);

        // All ties keep the first index.
        fr.delete(); add(7); add(7); add(7);
        send_frame();
        wait_result(mn, idx, ovf, idx_s, ovf_s, lat);
        chk("t2_min", mn, 7);
        chk("t2_idx", idx, 0);

        // Single-sample frame held under back-pressure.
        ready_mode = 0;
        fr.delete(); add(-1);
        send_frame();
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("t3_o_valid", int'(bus.O_valid), 1);
            chk("t3_i_ready", int'(bus.I_ready), 0);
            chk("t3_min", int'(bus.O_min), -1);
            chk("t3_idx", int'(bus.O_idx), 0);
        end
        ready_mode = 1;
        gone = 1'b0;
        for (int n = 0; n < 10 && !gone; n++) begin
            @(negedge CLK);
            if (!bus.O_valid) gone = 1'b1;
        end
        chk("t3_released", int'(gone), 1);
        @(posedge CLK);
        #1;

        // Six samples against a 2-bit counter: overflow and saturated index.
        fr.delete(); add(0); add(1); add(2); add(3); add(-2); add(5);
        send_frame();
        wait_result(mn, idx, ovf, idx_s, ovf_s, lat);
        chk("t4_min", mn, -2);
        chk("t4_s_idx", idx_s, 3);
        chk("t4_s_ovf", ovf_s, 1);
        chk("t4_idx", idx, 4);
        chk("t4_ovf", ovf, 0);

        // Asynchronous reset mid-frame, then a clean frame.
        put(W'(10), 1'b0);
        put(W'(-20), 1'b0);
        put(W'(-30), 1'b0);
        #3;
        ASYNCRESETN = 1'b0;
        #1;
        chk("t5_async_o_valid", int'(bus.O_valid), 0);
        chk("t5_async_i_ready", int'(bus.I_ready), 1);
        chk("t5_async_o_min", int'(bus.O_min), 0);
        @(posedge CLK);
        #3;
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;
        fr.delete(); add(63); add(-1);
        send_frame();
        wait_result(mn, idx, ovf, idx_s, ovf_s, lat);
        chk("t5_min", mn, -1);
        chk("t5_idx", idx, 1);
        chk("t5_ovf", ovf, 0);

        // Exactly 2^CNT_W samples: no overflow, last index representable.
        fr.delete();
        for (int i = 0; i < 255; i++) add(20);
        add(-7);
        send_frame();
        wait_result(mn, idx, ovf, idx_s, ovf_s, lat);
        chk("t6a_min", mn, -7);
        chk("t6a_idx", idx, 255);
        chk("t6a_ovf", ovf, 0);

        // One more sample: overflow, index saturated.
        fr.delete();
        for (int i = 0; i < 256; i++) add(20);
        add(-7);
        send_frame();
        wait_result(mn, idx, ovf, idx_s, ovf_s, lat);
        chk("t6b_min", mn, -7);
        chk("t6b_idx", idx, 255);
        chk("t6b_ovf", ovf, 1);

        // Randomized frames with input gaps and output back-pressure.
        gap_en = 1'b1;
        ready_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            len = (f % 50 == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8));
            fr.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0:       v = -7'sd64;
                    1:       v = 7'sd63;
                    2:       v = W'($urandom_range(0, 3));
                    default: v = W'($urandom_range(0, 127));
                endcase
                fr.push_back(v);
            end
            send_frame();
        end
        ready_mode = 1;
        gone = 1'b0;
        for (int n = 0; n < 100 && !gone; n++) begin
            @(negedge CLK);
            if (!bus.O_valid && !exp_hold) gone = 1'b1;
        end
        chk("drain", int'(gone), 1);
        chk("frames_consumed", consumed, sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
